sha256_compress: RTL and testbench
==================================

SHA256_COMPRESS -- requirements
Module: sha256_compress

Interface
REQ-001 SHALL have parameter ROUNDS, default 64, number of compression rounds per block; legal range 1..64; values below 64 exist only for reduced-round test.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port start, input, 1, begin a block; sampled only in IDLE.
REQ-005 SHALL have port h_in, input, 256, chaining value; H0 in [255:224] through H7 in [31:0]; sampled with start.
REQ-006 SHALL have port w_valid, input, 1, schedule word w_data valid this cycle.
REQ-007 SHALL have port w_data, input, 32, schedule word W[t].
REQ-008 SHALL have port w_ready, output, 1, block accepts a word this cycle.
REQ-009 SHALL have port t_idx, output, 6, index t of the next word expected, for the schedule generator.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-011 SHALL have port digest, output, 256, resulting hash; same packing as h_in.
REQ-012 SHALL have port digest_valid, output, 1, one-cycle pulse when digest is updated.

Function
REQ-013 SHALL implement states IDLE, ROUND, FINAL and DONE.
REQ-014 IDLE with start=1 SHALL load working registers a..h and saved H0..H7 from h_in, clear t to 0, and go to ROUND.
REQ-015 IDLE with start=0 SHALL hold all state.
REQ-016 ROUND SHALL drive w_ready=1 and t_idx=t; IDLE, FINAL and DONE SHALL drive w_ready=0.
REQ-017 A word SHALL transfer only on a cycle where w_valid and w_ready are both 1.
REQ-018 On each transfer the block SHALL execute one FIPS 180-4 SHA-256 round using K[t] from an internal 64-entry constant ROM, then increment t.
REQ-019 Round arithmetic: T1 = h + Sigma1(e) + Ch(e,f,g) + K[t] + W; T2 = Sigma0(a) + Maj(a,b,c); all additions modulo 2^32 with carries discarded.
REQ-020 In ROUND with w_valid=0, a..h and t SHALL hold; stalls of any length are legal.
REQ-021 The transfer with t = ROUNDS-1 SHALL move the state to FINAL.
REQ-022 FINAL SHALL, in one cycle, set digest[i] = H[i] + working register i (mod 2^32), then go to DONE.
REQ-023 DONE SHALL assert digest_valid for exactly that one cycle, then go to IDLE.
REQ-024 digest SHALL hold its value until the next FINAL or reset.
REQ-025 With w_valid held at 1, digest_valid SHALL be high in the 66th cycle after the edge that samples start, for ROUNDS=64.
REQ-026 start asserted outside IDLE SHALL be ignored; it SHALL NOT be queued.
REQ-027 w_valid asserted outside ROUND SHALL be ignored, and no word SHALL be consumed.
REQ-028 start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted, allowing back-to-back blocks with one idle cycle between them.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, t=0, a..h=0, H=0, digest=0, digest_valid=0, w_ready=0 and busy=0, regardless of clock.
REQ-030 rst asserted mid-block SHALL abandon the block; no digest_valid SHALL follow, and the next start SHALL run a full block from t=0.

Configuration
REQ-031 Macro SHA256_COMPRESS_IV_EN, when defined, SHALL add input port use_iv (1 bit, sampled with start); use_iv=1 SHALL load the SHA-256 initial value 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19 instead of h_in.
REQ-032 Without SHA256_COMPRESS_IV_EN, the use_iv port SHALL NOT exist and h_in SHALL always be loaded.

Verification
REQ-033 h_in=IV; W = schedule of "abc" (61626380, 0 x14, 00000018, then extended words) with w_valid held at 1 -> digest_valid in cycle 66; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-034 h_in=IV; empty-message schedule (80000000, then zeros) -> digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-035 Repeat REQ-033 with w_valid randomly low about 50% of cycles -> identical digest; t_idx advances only on transfers; exactly 64 words are consumed.
REQ-036 rst pulsed at t=20 -> busy=0, digest=0, w_ready=0 at once; a following abc block gives the REQ-033 digest.
REQ-037 start pulsed at t=10 and in the DONE cycle -> ignored; exactly one digest_valid pulse and the correct digest.
REQ-038 With SHA256_COMPRESS_IV_EN defined: use_iv=1, h_in=0, abc schedule -> REQ-033 digest; use_iv=0, h_in=IV -> same digest.

Source files
------------

// File: rtl/sha256_compress.sv
// sha256_compress: iterative SHA-256 compression function, one round per
// accepted schedule word. The schedule words W[t] come from an external
// generator via a valid/ready handshake; t_idx tells it which word is next.
// Optional build macro SHA256_COMPRESS_IV_EN adds a use_iv input that loads
// the standard SHA-256 initial value instead of h_in.
module sha256_compress #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] h_in,
`ifdef SHA256_COMPRESS_IV_EN
    input  logic         use_iv,
`endif
    input  logic         w_valid,
    input  logic [31:0]  w_data,
    output logic         w_ready,
    output logic [5:0]   t_idx,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

`ifdef SHA256_COMPRESS_IV_EN
    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t       state;
    logic [5:0]   t;
    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [255:0] h_save;
    logic [255:0] h_load;
    logic [31:0]  big_s0, big_s1, ch, maj, t1, t2;

    assign t_idx = t;

    // Chaining value captured at start: h_in, or the standard IV when selected.
    always_comb begin
`ifdef SHA256_COMPRESS_IV_EN
        h_load = use_iv ? SHA256_IV : h_in;
`else
        h_load = h_in;
`endif
    end

    // One SHA-256 round worth of combinational arithmetic on the working set.
    always_comb begin
        big_s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
        ch     = (e & f) ^ (~e & g);
        t1     = h + big_s1 + ch + K[t] + w_data;
        big_s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
        maj    = (a & b) ^ (a & c) ^ (b & c);
        t2     = big_s0 + maj;
    end

    // Control FSM with registered handshake/status outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            t            <= '0;
            a            <= '0;
            b            <= '0;
            c            <= '0;
            d            <= '0;
            e            <= '0;
            f            <= '0;
            g            <= '0;
            h            <= '0;
            h_save       <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            w_ready      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a       <= h_load[255:224];
                        b       <= h_load[223:192];
                        c       <= h_load[191:160];
                        d       <= h_load[159:128];
                        e       <= h_load[127:96];
                        f       <= h_load[95:64];
                        g       <= h_load[63:32];
                        h       <= h_load[31:0];
                        h_save  <= h_load;
                        t       <= '0;
                        w_ready <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ROUND;
                    end
                end
                ROUND: begin
                    if (w_valid && w_ready) begin
                        h <= g;
                        g <= f;
                        f <= e;
                        e <= d + t1;
                        d <= c;
                        c <= b;
                        b <= a;
                        a <= t1 + t2;
                        t <= t + 6'd1;
                        if (t == T_LAST) begin
                            w_ready <= 1'b0;
                            state   <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    digest <= {h_save[255:224] + a, h_save[223:192] + b,
                               h_save[191:160] + c, h_save[159:128] + d,
                               h_save[127:96]  + e, h_save[95:64]   + f,
                               h_save[63:32]   + g, h_save[31:0]    + h};
                    digest_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    digest_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: directed checks of sha256_compress against the
// published "abc" and empty-message SHA-256 digests, with stalls, ignored
// starts, mid-block reset and back-to-back blocks.
module tb_sha256_compress;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [255:0] h_in = '0;
`ifdef SHA256_COMPRESS_IV_EN
    logic         use_iv = 1'b0;
`endif
    logic         w_valid = 1'b0;
    logic [31:0]  w_data = '0;
    logic         w_ready;
    logic [5:0]   t_idx;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] wsched [64];

    sha256_compress #(.ROUNDS(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .h_in         (h_in),
`ifdef SHA256_COMPRESS_IV_EN
        .use_iv       (use_iv),
`endif
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .t_idx        (t_idx),
        .busy         (busy),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Single-block messages here differ only in W[0] and W[15].
    task automatic build_sched(input logic [31:0] w0, input logic [31:0] w15);
        for (int i = 0; i < 64; i++) begin
            if (i == 0)       wsched[i] = w0;
            else if (i < 15)  wsched[i] = '0;
            else if (i == 15) wsched[i] = w15;
            else wsched[i] = ss1(wsched[i-2]) + wsched[i-7] + ss0(wsched[i-15]) + wsched[i-16];
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one block from an IDLE negedge; returns at the IDLE negedge after
    // DONE, or after the reset sequence if abort_at >= 0.
    task automatic run_block(input logic [255:0] hv, input logic iv, input bit stall,
                             input int ign_t, input bit start_in_done, input int abort_at,
                             input logic [255:0] exp, input string tag);
        int words;
        int cyc;
        bit v;
        h_in = hv;
`ifdef SHA256_COMPRESS_IV_EN
        use_iv = iv;
`else
        if (iv) h_in = IV;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        h_in  = ~hv;
        cyc   = 1;
        words = 0;
        while (words < 64 && cyc < 400) begin
            chk({tag, " t_idx"},   t_idx, words);
            chk({tag, " w_ready"}, w_ready, 1);
            chk({tag, " busy"},    busy, 1);
            chk({tag, " dv_round"}, digest_valid, 0);
            if (words == abort_at) begin
                w_valid = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk({tag, " rst_busy"},    busy, 0);
                chk({tag, " rst_w_ready"}, w_ready, 0);
                chk({tag, " rst_digest"},  digest, 0);
                chk({tag, " rst_dv"},      digest_valid, 0);
                chk({tag, " rst_t_idx"},   t_idx, 0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 70; k++) begin
                    w_valid = 1'b1;
                    w_data  = $urandom;
                    @(negedge clk);
                    chk({tag, " post_rst_busy"}, busy, 0);
                    chk({tag, " post_rst_dv"},   digest_valid, 0);
                end
                w_valid = 1'b0;
                return;
            end
            v       = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            w_valid = v;
            w_data  = v ? wsched[words] : $urandom;
            start   = (words == ign_t);
            @(negedge clk);
            cyc++;
            if (v) words++;
        end
        start = 1'b0;
        chk({tag, " words_consumed"}, words, 64);
        // FINAL: w_valid offered but must not be taken
        w_valid = 1'b1;
        w_data  = $urandom;
        chk({tag, " final_w_ready"}, w_ready, 0);
        chk({tag, " final_busy"},    busy, 1);
        chk({tag, " final_dv"},      digest_valid, 0);
        @(negedge clk);
        cyc++;
        // DONE
        chk({tag, " done_dv"},      digest_valid, 1);
        chk({tag, " digest"},       digest, exp);
        chk({tag, " done_busy"},    busy, 1);
        chk({tag, " done_w_ready"}, w_ready, 0);
        if (!stall) chk({tag, " dv_cycle"}, cyc, 66);
        start = start_in_done;
        @(negedge clk);
        start   = 1'b0;
        w_valid = 1'b0;
        // IDLE
        chk({tag, " idle_dv"},     digest_valid, 0);
        chk({tag, " idle_busy"},   busy, 0);
        chk({tag, " digest_hold"}, digest, exp);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset busy",    busy, 0);
        chk("reset w_ready", w_ready, 0);
        chk("reset t_idx",   t_idx, 0);
        chk("reset digest",  digest, 0);
        chk("reset dv",      digest_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // IDLE without start holds; w_valid is ignored
        h_in = IV;
        for (int k = 0; k < 3; k++) begin
            w_valid = 1'b1;
            w_data  = $urandom;
            @(negedge clk);
            chk("idle_hold busy",    busy, 0);
            chk("idle_hold w_ready", w_ready, 0);
            chk("idle_hold t_idx",   t_idx, 0);
            chk("idle_hold digest",  digest, 0);
        end
        w_valid = 1'b0;

        // "abc", full rate, then empty message back-to-back
        build_sched(32'h61626380, 32'h00000018);
        run_block(IV, 1'b0, 1'b0, -1, 1'b0, -1, ABC_DIG, "abc");
        build_sched(32'h80000000, 32'h00000000);
        run_block(IV, 1'b0, 1'b0, -1, 1'b0, -1, EMPTY_DIG, "empty");

        // "abc" with random stalls, start at t=10 and in DONE both ignored
        build_sched(32'h61626380, 32'h00000018);
        run_block(IV, 1'b0, 1'b1, 10, 1'b1, -1, ABC_DIG, "abc_stall");
        for (int k = 0; k < 3; k++) begin
            w_valid = 1'b1;
            @(negedge clk);
            chk("no_queue busy", busy, 0);
            chk("no_queue dv",   digest_valid, 0);
        end
        w_valid = 1'b0;

        // Reset at t=20 abandons the block; next block runs clean
        run_block(IV, 1'b0, 1'b0, -1, 1'b0, 20, ABC_DIG, "abort");
        run_block(IV, 1'b0, 1'b0, -1, 1'b0, -1, ABC_DIG, "abc_after_rst");

`ifdef SHA256_COMPRESS_IV_EN
        run_block('0, 1'b1, 1'b0, -1, 1'b0, -1, ABC_DIG, "use_iv1");
        run_block(IV, 1'b0, 1'b0, -1, 1'b0, -1, ABC_DIG, "use_iv0");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
